// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for the unified memory port (optional ARB_RR_EN round-robin)
module mem_port_arbiter #(
    parameter int LAT   = 2,
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_done,
    output logic [31:0] dm_rdata,
    output logic        mem_sel,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             pick_dm;
    logic             mem_sel_d, mem_en_d, mem_we_d, busy_d;
    logic             if_gnt_d, dm_gnt_d, if_done_d, dm_done_d;
    logic [31:0]      mem_addr_d, mem_wdata_d, if_rdata_d, dm_rdata_d;

`ifdef ARB_RR_EN
    // last_owner: 0 = IF, 1 = DM; on a tie the other requester wins
    logic last_owner;

    always_ff @(posedge clk) begin
        if (rst)
            last_owner <= 1'b0;
        else if (state == IDLE && (if_req || dm_req))
            last_owner <= pick_dm;
    end

    assign pick_dm = dm_req & (~if_req | ~last_owner);
`else
    assign pick_dm = dm_req;
`endif

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        mem_sel_d   = mem_sel;
        mem_en_d    = mem_en;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_rdata_d  = if_rdata;
        dm_rdata_d  = dm_rdata;
        busy_d      = busy;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d     = ACCESS;
                    cnt_d       = CNT_W'(LAT - 1);
                    mem_sel_d   = pick_dm;
                    mem_addr_d  = pick_dm ? dm_addr : if_addr;
                    mem_wdata_d = pick_dm ? dm_wdata : 32'h0;
                    mem_we_d    = pick_dm & dm_we;
                    mem_en_d    = 1'b1;
                    busy_d      = 1'b1;
                    dm_gnt_d    = pick_dm;
                    if_gnt_d    = ~pick_dm;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    // Last access cycle: read data is valid now, writes included
                    state_d  = DONE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (mem_sel) begin
                        dm_rdata_d = mem_rdata;
                        dm_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_sel   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            if_rdata  <= 32'h0;
            dm_rdata  <= 32'h0;
            busy      <= 1'b0;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            mem_sel   <= mem_sel_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_rdata  <= if_rdata_d;
            dm_rdata  <= dm_rdata_d;
            busy      <= busy_d;
            if_gnt    <= if_gnt_d;
            dm_gnt    <= dm_gnt_d;
            if_done   <= if_done_d;
            dm_done   <= dm_done_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized bench for mem_port_arbiter (ARB_RR_EN aware)
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_gnt, if_done, dm_gnt, dm_done;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        mem_sel, mem_en, mem_we, busy;

    mem_port_arbiter #(.LAT(LAT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int n = 0;

    // Transaction-level reference: one active transaction, described by its grant cycle s
    bit          act = 0;
    int          s = 0;
    bit          own = 0;
    bit          m_sel = 0, m_we = 0, last_dm = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, e_ifr = 0, e_dmr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic cyc();
        bit pd, in_acc, at_gnt, at_done;
        if (rst) begin
            act = 0; e_ifr = 0; e_dmr = 0; m_addr = 0; m_wdata = 0;
            m_sel = 0; m_we = 0; last_dm = 0;
        end else begin
            if (act && n == s + LAT - 1) begin
                if (own) e_dmr = mem_rdata;
                else     e_ifr = mem_rdata;
            end
            if ((!act || n > s + LAT) && (if_req || dm_req)) begin
`ifdef ARB_RR_EN
                pd = dm_req && (!if_req || !last_dm);
`else
                pd = dm_req;
`endif
                act = 1; s = n + 1; own = pd; m_sel = pd; last_dm = pd;
                m_addr  = pd ? dm_addr : if_addr;
                m_wdata = pd ? dm_wdata : 32'h0;
                m_we    = pd && dm_we;
            end
        end
        @(posedge clk);
        #1;
        n++;
        in_acc  = act && n >= s && n < s + LAT;
        at_gnt  = act && n == s;
        at_done = act && n == s + LAT;
        chk("busy",      32'(busy),    32'(in_acc || at_done));
        chk("if_gnt",    32'(if_gnt),  32'(at_gnt && !own));
        chk("dm_gnt",    32'(dm_gnt),  32'(at_gnt && own));
        chk("if_done",   32'(if_done), 32'(at_done && !own));
        chk("dm_done",   32'(dm_done), 32'(at_done && own));
        chk("mem_en",    32'(mem_en),  32'(in_acc));
        chk("mem_we",    32'(mem_we),  32'(in_acc && m_we));
        chk("mem_sel",   32'(mem_sel), 32'(m_sel));
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("if_rdata",  if_rdata,  e_ifr);
        chk("dm_rdata",  dm_rdata,  e_dmr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", n);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, ig, id, dg, dd, ng;
        bit if_new, dm_new;
        bit order [4];
        rst = 1; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
        cyc();
        chk("reset_busy", 32'(busy), 32'h0);
        rst = 0;
        cyc();

        // IF read
        if_req = 1; if_addr = 32'h40; mem_rdata = 32'h24020005; base = n;
        cyc(); chk("tp1_gnt", 32'(if_gnt), 32'h1); chk("tp1_sel", 32'(mem_sel), 32'h0);
        cyc(); cyc();
        chk("tp1_done", 32'(if_done), 32'h1); chk("tp1_rdata", if_rdata, 32'h24020005);
        if_req = 0;
        cyc(); chk("tp1_idle", 32'(busy), 32'h0);

        // DM write
        dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_wdata = 32'hDEADBEEF; mem_rdata = 32'h12345678;
        cyc(); chk("tp2_we", 32'(mem_we), 32'h1); chk("tp2_wdata", mem_wdata, 32'hDEADBEEF);
        cyc(); cyc();
        chk("tp2_done", 32'(dm_done), 32'h1); chk("tp2_ifr", if_rdata, 32'h24020005);
        dm_req = 0; dm_we = 0;
        cyc();

        // Simultaneous requests, each held until its own done
        if_req = 1; dm_req = 1; base = n; ig = -1; id = -1; dg = -1; dd = -1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (if_gnt)  ig = n - base;
            if (dm_gnt)  dg = n - base;
            if (if_done) begin id = n - base; if_req = 0; end
            if (dm_done) begin dd = n - base; dm_req = 0; end
        end
`ifdef ARB_RR_EN
        chk("tp3_if_gnt", 32'(ig), 32'd1); chk("tp3_if_done", 32'(id), 32'd3);
        chk("tp3_dm_gnt", 32'(dg), 32'd5); chk("tp3_dm_done", 32'(dd), 32'd7);
`else
        chk("tp3_dm_gnt", 32'(dg), 32'd1); chk("tp3_dm_done", 32'(dd), 32'd3);
        chk("tp3_if_gnt", 32'(ig), 32'd5); chk("tp3_if_done", 32'(id), 32'd7);
`endif

        // Requester changes address after its grant
        dm_req = 1; dm_we = 0; dm_addr = 32'h20;
        cyc(); chk("tp4_gnt", 32'(dm_gnt), 32'h1);
        dm_addr = 32'h44; mem_rdata = 32'hCAFEF00D;
        cyc(); chk("tp4_addr", mem_addr, 32'h20);
        cyc(); chk("tp4_rdata", dm_rdata, 32'hCAFEF00D);
        dm_req = 0;
        cyc();

        // Reset in the middle of a DM write
        dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'h55AA55AA;
        cyc(); cyc();
        rst = 1;
        cyc();
        chk("tp5_en", 32'(mem_en), 32'h0); chk("tp5_done", 32'(dm_done), 32'h0);
        chk("tp5_rdata", dm_rdata, 32'h0); chk("tp5_busy", 32'(busy), 32'h0);
        rst = 0; dm_req = 0; dm_we = 0;
        cyc();

        // Continuous contention: grant order
        if_req = 1; dm_req = 1; ng = 0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            cyc();
            if (if_gnt || dm_gnt) begin order[ng] = dm_gnt; ng++; end
        end
        chk("tp6_count", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            chk($sformatf("tp6_order%0d", k), 32'(order[k]), 32'((k % 2) == 0));
`else
            chk($sformatf("tp6_order%0d", k), 32'(order[k]), 32'h1);
`endif
        end
        if_req = 0; dm_req = 0;
        for (int k = 0; k < LAT + 3; k++) cyc();

        // Randomized traffic with occasional resets
        if_new = 0; dm_new = 0;
        for (int k = 0; k < 2000; k++) begin
            if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
            mem_rdata = $urandom; dm_we = $urandom_range(0, 1);
            rst = ($urandom_range(0, 99) == 0);
            if (rst) begin
                if_req = 0; dm_req = 0; if_new = 0; dm_new = 0;
            end else begin
                if (if_done) if_new = 1;
                else if (if_new) begin if_req = $urandom_range(0, 1); if_new = 0; end
                else if (!if_req) if_req = ($urandom_range(0, 2) == 0);
                if (dm_done) dm_new = 1;
                else if (dm_new) begin dm_req = $urandom_range(0, 1); dm_new = 0; end
                else if (!dm_req) dm_req = ($urandom_range(0, 2) == 0);
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
